ace_snoop_responder: RTL
========================

# ace_snoop_responder

Master-side ACE snoop responder: accepts snoop requests on the AC channel from the coherency interconnect, looks up the local cache line state through a simple tag/data port, and answers on CR and, when needed, CD. It also issues the resulting line-state update back to the cache. It sits between a private cache controller and its ACE slave port on the CCU, and is the receiving end of the snoops the CCU initiates. One snoop is in flight at a time.

## Interface
Parameters:
- AddrWidth, 64, AC address width
- DataWidth, 64, CD data width per beat
- BeatsPerLine, 4, CD beats per cache line (≥1); line width = DataWidth*BeatsPerLine

Ports:
- clk_i  in  1  clock; single clock domain
- rst_ni  in  1  reset; asynchronous, active-low
- ac_valid_i / ac_ready_o  in/out  1  AC handshake
- ac_addr_i  in  AddrWidth  snoop address (line aligned)
- ac_snoop_i  in  4  AC snoop type
- cr_valid_o / cr_ready_i  out/in  1  CR handshake
- cr_resp_o  out  5  {WasUnique, IsShared, PassDirty, Error, DataTransfer}
- cd_valid_o / cd_ready_i  out/in  1  CD handshake
- cd_data_o  out  DataWidth  CD beat data
- cd_last_o  out  1  last CD beat
- lookup_req_o / lookup_gnt_i  out/in  1  cache lookup handshake
- lookup_addr_o  out  AddrWidth  registered ac_addr_i
- lookup_hit_i, lookup_dirty_i, lookup_shared_i  in  1 each  line state, valid in grant cycle
- lookup_data_i  in  DataWidth*BeatsPerLine  line data, valid in grant cycle; beat 0 = LSBs
- upd_valid_o  out  1  one-cycle state-update pulse
- upd_inval_o, upd_clean_o, upd_shared_o  out  1 each  update actions (invalidate / clear dirty / set shared)

## Operation
- FSM: IDLE → LOOKUP → RESP → (DATA) → IDLE.
- IDLE: ac_ready_o=1; on AC handshake register addr, snoop; → LOOKUP.
- LOOKUP: lookup_req_o=1 until lookup_gnt_i; in grant cycle register hit/dirty/shared/line data and compute response; → RESP.
- Response (hit; miss ⇒ cr_resp_o=0, no update):
  - ReadOnce 0000: DT=1, IsShared=1, PassDirty=0; no update.
  - ReadShared 0001, ReadNotSharedDirty 0011: DT=1, IsShared=1, PassDirty=dirty; update shared=1, clean=dirty.
  - ReadClean 0010: DT=1, IsShared=1, PassDirty=0; update shared=1.
  - ReadUnique 0111: DT=1, PassDirty=dirty; update inval=1.
  - CleanShared 1000: DT=dirty, PassDirty=dirty; update clean=dirty (upd_valid_o only if dirty).
  - CleanInvalid 1001: DT=dirty, PassDirty=dirty; update inval=1.
  - MakeInvalid 1101: DT=0; update inval=1.
  - Any other encoding: cr_resp_o=5'b00010 (Error), no data, no update, no lookup (IDLE → RESP directly).
- WasUnique = hit & !shared (see Configuration).
- upd_valid_o pulses in the cycle after grant (first RESP cycle).
- RESP: cr_valid_o held with stable cr_resp_o until cr_ready_i; then → DATA if DT else IDLE.
- DATA: beat counter 0..BeatsPerLine-1, cd_data_o = beat slice of registered line; cd_last_o on final beat; advance on cd_ready_i; after last handshake → IDLE.

## Timing
- Reset (async): state IDLE; all outputs 0 except ac_ready_o=1 (combinational from IDLE); beat counter 0.
- AC handshake at cycle T → lookup_req_o at T+1; grant at T+1 → cr_valid_o and upd_valid_o at T+2.
- Earliest CD beat 0: cycle after CR handshake; one beat per cycle with cd_ready_i=1.
- Min snoop turnaround (DT=0, zero stalls): 3 cycles; with data: 3+BeatsPerLine.
- valid signals never drop without handshake; payload stable while valid && !ready.
- ac_ready_o=0 outside IDLE; new AC accepted earliest in the cycle after the final CR/CD handshake.
- Reset mid-transfer: aborts immediately, no partial update repeated.

## Configuration
- ACE_SNOOP_WAS_UNIQUE_EN defined: cr_resp_o[4] = hit & !lookup_shared_i.
- Undefined: cr_resp_o[4] tied 0 (permitted by ACE); all else identical.

## Test plan
- ReadShared, hit dirty unshared, line={4,3,2,1}: cr_resp_o=5'b11101 (with macro), CD beats 1,2,3,4, cd_last_o on beat 4; upd shared=1, clean=1.
- MakeInvalid hit: cr_resp_o=5'b00000 (macro off), no CD, upd_valid_o with inval=1 at T+2.
- Snoop 0100 (unsupported): cr_resp_o=5'b00010 at T+1, lookup_req_o never asserted.
- ReadUnique miss, lookup_gnt_i delayed 5 cycles: lookup_req_o held 5 cycles, cr_resp_o=0, no CD/update.
- CD backpressure: cd_ready_i toggling 1,0,0,1…: cd_data_o stable while stalled, exactly 4 beats, ac_ready_o stays 0 until last.
- Reset asserted in DATA beat 2: all valids 0 asynchronously, ac_ready_o=1 after release, next snoop processed normally.

Source files
------------

// File: rtl/ace_snoop_responder_if.sv
// ace_snoop_responder_if
// Bundles the AC/CR/CD snoop channels, the cache lookup port and the line-state
// update port of the ACE snoop responder. Signal names keep the responder's
// point of view (_i = into the responder, _o = out of it).
// Modports:
//   master : the responder itself (ACE master side, receives snoops)
//   slave  : the environment (interconnect plus cache controller)
// Parameters: AddrWidth (AC address), DataWidth (CD beat), BeatsPerLine (beats per line).
interface ace_snoop_responder_if #(
    parameter int unsigned AddrWidth    = 64,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned BeatsPerLine = 4
) ();
    logic                              ac_valid_i;
    logic                              ac_ready_o;
    logic [AddrWidth-1:0]              ac_addr_i;
    logic [3:0]                        ac_snoop_i;
    logic                              cr_valid_o;
    logic                              cr_ready_i;
    logic [4:0]                        cr_resp_o;
    logic                              cd_valid_o;
    logic                              cd_ready_i;
    logic [DataWidth-1:0]              cd_data_o;
    logic                              cd_last_o;
    logic                              lookup_req_o;
    logic                              lookup_gnt_i;
    logic [AddrWidth-1:0]              lookup_addr_o;
    logic                              lookup_hit_i;
    logic                              lookup_dirty_i;
    logic                              lookup_shared_i;
    logic [DataWidth*BeatsPerLine-1:0] lookup_data_i;
    logic                              upd_valid_o;
    logic                              upd_inval_o;
    logic                              upd_clean_o;
    logic                              upd_shared_o;

    modport master (
        input  ac_valid_i, ac_addr_i, ac_snoop_i, cr_ready_i, cd_ready_i,
        input  lookup_gnt_i, lookup_hit_i, lookup_dirty_i, lookup_shared_i, lookup_data_i,
        output ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o,
        output lookup_req_o, lookup_addr_o,
        output upd_valid_o, upd_inval_o, upd_clean_o, upd_shared_o
    );

    modport slave (
        output ac_valid_i, ac_addr_i, ac_snoop_i, cr_ready_i, cd_ready_i,
        output lookup_gnt_i, lookup_hit_i, lookup_dirty_i, lookup_shared_i, lookup_data_i,
        input  ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o,
        input  lookup_req_o, lookup_addr_o,
        input  upd_valid_o, upd_inval_o, upd_clean_o, upd_shared_o
    );
endinterface

// File: rtl/ace_snoop_responder.sv
// ace_snoop_responder
// Master-side ACE snoop responder. Accepts one AC snoop at a time, looks the line
// up in the local cache, answers on CR (and CD when data is passed) and issues a
// one-cycle line-state update pulse back to the cache.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : ace_snoop_responder_if.master (AC, CR, CD, lookup and update channels)
// Optional feature: define ACE_SNOOP_WAS_UNIQUE_EN to drive CR WasUnique from the
// lookup result; otherwise WasUnique is tied 0.
module ace_snoop_responder #(
    parameter int unsigned AddrWidth    = 64,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned BeatsPerLine = 4
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    ace_snoop_responder_if.master bus
);
    localparam int unsigned LineWidth = DataWidth * BeatsPerLine;
    localparam int unsigned BeatW     = (BeatsPerLine > 1) ? $clog2(BeatsPerLine) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BeatsPerLine - 1);

    typedef enum logic [1:0] {StIdle, StLookup, StResp, StData} state_e;

    state_e               r_state, w_state_next;
    logic [AddrWidth-1:0] r_addr;
    logic [3:0]           r_snoop;
    logic [LineWidth-1:0] r_line;
    logic [4:0]           r_resp;
    logic                 r_dt;
    logic [BeatW-1:0]     r_beat;
    logic                 r_upd_valid, r_upd_inval, r_upd_clean, r_upd_shared;

    logic       w_ac_hs, w_gnt_hs, w_cd_hs;
    logic       w_dt, w_is, w_pd, w_inval, w_clean, w_shared, w_wu;
    logic [4:0] w_resp;

    function automatic logic snoop_supported(input logic [3:0] snoop);
        case (snoop)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0111, 4'b1000, 4'b1001, 4'b1101: snoop_supported = 1'b1;
            default:                            snoop_supported = 1'b0;
        endcase
    endfunction

    assign w_ac_hs  = (r_state == StIdle) && bus.ac_valid_i;
    assign w_gnt_hs = (r_state == StLookup) && bus.lookup_gnt_i;
    assign w_cd_hs  = (r_state == StData) && bus.cd_ready_i;

    // Response and update actions for a hit, decoded from the registered snoop
    // and the grant-cycle line state.
    always_comb begin
        w_dt     = 1'b0;
        w_is     = 1'b0;
        w_pd     = 1'b0;
        w_inval  = 1'b0;
        w_clean  = 1'b0;
        w_shared = 1'b0;
        case (r_snoop)
            4'b0000: begin w_dt = 1'b1; w_is = 1'b1; end
            4'b0001, 4'b0011: begin
                w_dt     = 1'b1;
                w_is     = 1'b1;
                w_pd     = bus.lookup_dirty_i;
                w_shared = 1'b1;
                w_clean  = bus.lookup_dirty_i;
            end
            4'b0010: begin w_dt = 1'b1; w_is = 1'b1; w_shared = 1'b1; end
            4'b0111: begin w_dt = 1'b1; w_pd = bus.lookup_dirty_i; w_inval = 1'b1; end
            4'b1000: begin
                w_dt    = bus.lookup_dirty_i;
                w_pd    = bus.lookup_dirty_i;
                w_clean = bus.lookup_dirty_i;
            end
            4'b1001: begin
                w_dt    = bus.lookup_dirty_i;
                w_pd    = bus.lookup_dirty_i;
                w_inval = 1'b1;
            end
            4'b1101: w_inval = 1'b1;
            default: ;
        endcase
`ifdef ACE_SNOOP_WAS_UNIQUE_EN
        w_wu = bus.lookup_hit_i & ~bus.lookup_shared_i;
`else
        w_wu = 1'b0;
`endif
        // A miss answers all-zero and never touches the cache.
        w_resp = bus.lookup_hit_i ? {w_wu, w_is, w_pd, 1'b0, w_dt} : 5'b00000;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        bus.ac_ready_o   = 1'b0;
        bus.lookup_req_o = 1'b0;
        bus.cr_valid_o   = 1'b0;
        bus.cd_valid_o   = 1'b0;
        bus.cd_last_o    = 1'b0;
        unique case (r_state)
            StIdle: begin
                bus.ac_ready_o = 1'b1;
                if (bus.ac_valid_i) begin
                    // Unsupported snoops skip the lookup and answer Error directly.
                    w_state_next = snoop_supported(bus.ac_snoop_i) ? StLookup : StResp;
                end
            end
            StLookup: begin
                bus.lookup_req_o = 1'b1;
                if (bus.lookup_gnt_i) w_state_next = StResp;
            end
            StResp: begin
                bus.cr_valid_o = 1'b1;
                if (bus.cr_ready_i) w_state_next = r_dt ? StData : StIdle;
            end
            StData: begin
                bus.cd_valid_o = 1'b1;
                bus.cd_last_o  = (r_beat == LastBeat);
                if (bus.cd_ready_i && (r_beat == LastBeat)) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr       <= '0;
            r_snoop      <= '0;
            r_line       <= '0;
            r_resp       <= '0;
            r_dt         <= 1'b0;
            r_beat       <= '0;
            r_upd_valid  <= 1'b0;
            r_upd_inval  <= 1'b0;
            r_upd_clean  <= 1'b0;
            r_upd_shared <= 1'b0;
        end else begin
            // Update outputs are a single-cycle pulse following the grant.
            r_upd_valid  <= 1'b0;
            r_upd_inval  <= 1'b0;
            r_upd_clean  <= 1'b0;
            r_upd_shared <= 1'b0;
            if (w_ac_hs) begin
                r_addr  <= bus.ac_addr_i;
                r_snoop <= bus.ac_snoop_i;
                if (!snoop_supported(bus.ac_snoop_i)) begin
                    r_resp <= 5'b00010;
                    r_dt   <= 1'b0;
                end
            end
            if (w_gnt_hs) begin
                r_line       <= bus.lookup_data_i;
                r_resp       <= w_resp;
                r_dt         <= bus.lookup_hit_i & w_dt;
                r_upd_valid  <= bus.lookup_hit_i & (w_inval | w_clean | w_shared);
                r_upd_inval  <= bus.lookup_hit_i & w_inval;
                r_upd_clean  <= bus.lookup_hit_i & w_clean;
                r_upd_shared <= bus.lookup_hit_i & w_shared;
            end
            if (w_cd_hs) begin
                r_beat <= (r_beat == LastBeat) ? '0 : r_beat + 1'b1;
            end
        end
    end

    always_comb begin
        bus.cd_data_o = '0;
        for (int b = 0; b < int'(BeatsPerLine); b++) begin
            if (r_beat == BeatW'(b)) bus.cd_data_o = r_line[b*DataWidth +: DataWidth];
        end
    end

    assign bus.lookup_addr_o = r_addr;
    assign bus.cr_resp_o     = r_resp;
    assign bus.upd_valid_o   = r_upd_valid;
    assign bus.upd_inval_o   = r_upd_inval;
    assign bus.upd_clean_o   = r_upd_clean;
    assign bus.upd_shared_o  = r_upd_shared;
endmodule
